// File: rtl/input_debounce_pkg.sv
// Shared constants for the switch/key input conditioner and the simple I/O read-byte packing.
// Also holds small counter-width helpers used by the debounce top and channel.
package input_debounce_pkg;

    localparam int unsigned DEBOUNCE_TICK_DIV_DEF = 50000;
    localparam int unsigned DEBOUNCE_TICKS_DEF    = 4;
    localparam int unsigned DEBOUNCE_NCH_DEF      = 8;

    // Bit positions of the switch and key fields in the simple I/O read byte.
    localparam int unsigned SW_LSB  = 4;
    localparam int unsigned KEY_LSB = 0;

    function automatic int unsigned tick_cnt_width(input int unsigned div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

    function automatic int unsigned debounce_cnt_width(input int unsigned ticks);
        return $clog2(ticks) + 1;
    endfunction

endpackage

// File: rtl/input_debounce_channel.sv
// One debounce channel: two-flop synchroniser, tick-qualified agreement counter,
// stable level flop and registered one-cycle rise/fall pulses.
module debounce_channel
    import input_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
    parameter logic        INIT_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic tick,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int unsigned    CW       = debounce_cnt_width(DEBOUNCE_TICKS);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

    logic          sync0;
    logic          sync1;
    logic          stable_prev;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync0       <= INIT_LEVEL;
            sync1       <= INIT_LEVEL;
            stable      <= INIT_LEVEL;
            stable_prev <= INIT_LEVEL;
            cnt         <= '0;
            rise        <= 1'b0;
            fall        <= 1'b0;
        end else begin
            sync0       <= raw;
            sync1       <= sync0;
            stable_prev <= stable;
            // Pulses trail the stable change by one cycle; reset loads both flops equal.
            rise        <= stable & ~stable_prev;
            fall        <= ~stable & stable_prev;
            if (tick) begin
                if (sync1 == stable) begin
                    cnt <= '0;
                end else if (cnt == CNT_LAST) begin
                    stable <= sync1;
                    cnt    <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/input_debounce.sv
// Switch/key input conditioner: shared sample tick plus N_CH debounce channels.
// Define INPUT_DEBOUNCE_EVT_LATCH_EN to build the sticky rise-event register.
module input_debounce
    import input_debounce_pkg::*;
#(
    parameter int unsigned     N_CH           = DEBOUNCE_NCH_DEF,
    parameter int unsigned     TICK_DIV       = DEBOUNCE_TICK_DIV_DEF,
    parameter int unsigned     DEBOUNCE_TICKS = DEBOUNCE_TICKS_DEF,
    parameter logic [N_CH-1:0] INIT_LEVEL     = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] raw_in,
    output logic [N_CH-1:0] stable,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic            tick,
    input  logic [N_CH-1:0] evt_clr,
    output logic [N_CH-1:0] evt_latched
);

    localparam int unsigned   TW        = tick_cnt_width(TICK_DIV);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    logic [TW-1:0] tick_cnt;
    logic [TW-1:0] tick_cnt_next;

    always_comb begin
        tick_cnt_next = (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
    end

    // tick is registered so it is high exactly while tick_cnt sits at TICK_LAST.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
            tick     <= 1'b0;
        end else begin
            tick_cnt <= tick_cnt_next;
            tick     <= (tick_cnt_next == TICK_LAST);
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
            .INIT_LEVEL     (INIT_LEVEL[i])
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .raw    (raw_in[i]),
            .tick   (tick),
            .stable (stable[i]),
            .rise   (rise[i]),
            .fall   (fall[i])
        );
    end

`ifdef INPUT_DEBOUNCE_EVT_LATCH_EN
    // Set dominates clear so a rise coinciding with a clear is not lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            evt_latched <= '0;
        end else begin
            evt_latched <= (evt_latched & ~evt_clr) | rise;
        end
    end
`else
    logic unused_evt_clr;
    assign unused_evt_clr = ^evt_clr;
    assign evt_latched    = '0;
`endif

endmodule

// File: tb/tb_input_debounce.sv
// Directed bench for input_debounce with TICK_DIV=4, DEBOUNCE_TICKS=3, N_CH=8.
// Expected event-latch values follow INPUT_DEBOUNCE_EVT_LATCH_EN.
module tb_input_debounce;

    localparam int unsigned N_CH = 8;

`ifdef INPUT_DEBOUNCE_EVT_LATCH_EN
    localparam logic LATCH_EXP = 1'b1;
`else
    localparam logic LATCH_EXP = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic [N_CH-1:0] raw_in;
    logic [N_CH-1:0] stable;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic            tick;
    logic [N_CH-1:0] evt_clr;
    logic [N_CH-1:0] evt_latched;

    int checks = 0;
    int errors = 0;

    int rise_cnt [N_CH];
    int fall_cnt [N_CH];
    int both_cnt = 0;
    int latch_bad = 0;

    input_debounce #(
        .N_CH           (N_CH),
        .TICK_DIV       (4),
        .DEBOUNCE_TICKS (3),
        .INIT_LEVEL     (8'h00)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .raw_in      (raw_in),
        .stable      (stable),
        .rise        (rise),
        .fall        (fall),
        .tick        (tick),
        .evt_clr     (evt_clr),
        .evt_latched (evt_latched)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < N_CH; i++) begin
            rise_cnt[i] = 0;
            fall_cnt[i] = 0;
        end
    end

    // Pulse accounting on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                rise_cnt[i] = rise_cnt[i] + int'(rise[i]);
                fall_cnt[i] = fall_cnt[i] + int'(fall[i]);
            end
            if ((rise & fall) != '0) both_cnt = both_cnt + 1;
        end
        if (evt_latched != '0 && !LATCH_EXP) latch_bad = latch_bad + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat;
        int last_tick;
        int n_tick;
        int bad_gap;
        int r_snap;
        int f_snap;
        int f_tot;
        bit found;

        rst     = 1'b0;
        raw_in  = '0;
        evt_clr = '0;
        #1;
        check("reset_stable", 32'(stable), 32'h00);
        check("reset_rise_fall", 32'({rise, fall}), 32'h0);
        check("reset_tick", 32'(tick), 32'h0);
        check("reset_latched", 32'(evt_latched), 32'h0);
        repeat (3) step();
        rst = 1'b1;

        // 1: idle after reset, tick period 4
        n_tick = 0; last_tick = -1; bad_gap = 0;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (tick) begin
                if (last_tick >= 0 && k - last_tick != 4) bad_gap++;
                last_tick = k;
                n_tick++;
            end
        end
        check("idle_tick_count", 32'(n_tick), 32'd10);
        check("idle_tick_gap", 32'(bad_gap), 32'd0);
        check("idle_stable", 32'(stable), 32'h00);
        check("idle_rise0", 32'(rise_cnt[0] + rise_cnt[7]), 32'd0);
        check("idle_fall0", 32'(fall_cnt[0] + fall_cnt[7]), 32'd0);

        // 2: clean step on channel 0
        raw_in[0] = 1'b1;
        lat = 0; found = 0;
        while (!found && lat < 20) begin
            step();
            lat++;
            if (stable[0]) found = 1;
        end
        check("step_latency_ok", 32'(found && lat >= 11 && lat <= 14), 32'd1);
        check("step_others", 32'(stable[7:1]), 32'h00);
        check("step_rise_now", 32'(rise), 32'h00);
        step();
        check("step_rise_pulse", 32'(rise), 32'h01);
        step();
        check("step_rise_end", 32'(rise), 32'h00);
        check("step_stable", 32'(stable), 32'h01);

        // 3: bounce on channel 3
        r_snap = rise_cnt[3]; f_snap = fall_cnt[3];
        for (int s = 0; s < 10; s++) begin
            raw_in[3] = ~raw_in[3];
            repeat (3) step();
        end
        check("bounce_hold", 32'(stable[3]), 32'd0);
        raw_in[3] = 1'b1;
        lat = 0; found = 0;
        while (!found && lat < 20) begin
            step();
            lat++;
            if (stable[3]) found = 1;
        end
        check("bounce_settled", 32'(found), 32'd1);
        repeat (3) step();
        check("bounce_one_rise", 32'(rise_cnt[3] - r_snap), 32'd1);
        check("bounce_no_fall", 32'(fall_cnt[3] - f_snap), 32'd0);

        // 4: two-tick glitch on channel 5
        r_snap = rise_cnt[5]; f_snap = fall_cnt[5];
        raw_in[5] = 1'b1;
        repeat (6) step();
        raw_in[5] = 1'b0;
        repeat (20) step();
        check("glitch_stable", 32'(stable[5]), 32'd0);
        check("glitch_pulses", 32'((rise_cnt[5] - r_snap) + (fall_cnt[5] - f_snap)), 32'd0);

        // 5: reset while channel 2 is mid-qualification
        f_tot = 0;
        for (int i = 0; i < N_CH; i++) f_tot += fall_cnt[i];
        r_snap = rise_cnt[2];
        raw_in[2] = 1'b1;
        lat = 0; found = 0;
        while (!found && lat < 30) begin
            step();
            lat++;
            if (u_dut.g_ch[2].u_ch.cnt == 3'd2) found = 1;
        end
        check("mid_count_reached", 32'(found), 32'd1);
        rst = 1'b0;
        #1;
        check("mid_reset_stable", 32'(stable), 32'h00);
        check("mid_reset_pulses", 32'({rise, fall, 7'd0, tick}), 32'h0);
        repeat (2) step();
        rst = 1'b1;
        lat = 0; found = 0;
        while (!found && lat < 20) begin
            step();
            lat++;
            if (stable[2]) found = 1;
        end
        check("requal_latency_ok", 32'(found && lat >= 11 && lat <= 14), 32'd1);
        repeat (3) step();
        for (int i = 0; i < N_CH; i++) f_tot -= fall_cnt[i];
        check("requal_no_fall", 32'(f_tot), 32'd0);
        check("requal_one_rise", 32'(rise_cnt[2] - r_snap), 32'd1);

        // 6: rise on channel 1 coinciding with its clear
        raw_in[1] = 1'b1;
        lat = 0; found = 0;
        while (!found && lat < 20) begin
            step();
            lat++;
            if (stable[1]) found = 1;
        end
        check("evt_stable1", 32'(found), 32'd1);
        step();
        check("evt_rise1", 32'(rise[1]), 32'd1);
        evt_clr[1] = 1'b1;
        step();
        evt_clr[1] = 1'b0;
        check("evt_set_wins", 32'(evt_latched[1]), 32'(LATCH_EXP));
        repeat (3) step();
        check("evt_sticky", 32'(evt_latched[1]), 32'(LATCH_EXP));
        evt_clr[1] = 1'b1;
        step();
        evt_clr[1] = 1'b0;
        check("evt_cleared", 32'(evt_latched[1]), 32'd0);
        step();

        check("never_both_edges", 32'(both_cnt), 32'd0);
        check("latch_tied_off", 32'(latch_bad), 32'd0);
        check("final_stable", 32'(stable), 32'h0f);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
